// File: rtl/pixel_history_reader.sv
// 64-entry circular pixel history for the decoder, with a single-register valid/ready read port.
// Define HIST_FWD_EN to forward same-cycle writes to a colliding read; otherwise read-before-write.
module pixel_history_reader #(
  parameter int unsigned INP_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [INP_BITS-1:0] wr_data,
  input  logic                rd_valid,
  input  logic [5:0]          rd_index,
  output logic                rd_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INP_BITS-1:0] out_data,
  output logic                out_miss,
  output logic [6:0]          count
);

  logic [INP_BITS-1:0] mem_q [64];
  logic [63:0]         valid_q;
  logic [5:0]          wp_q;
  logic [6:0]          count_q;
  logic                out_valid_q;
  logic [INP_BITS-1:0] out_data_q;
  logic                out_miss_q;

  logic                rd_fire;
  logic [INP_BITS-1:0] rd_data;
  logic                rd_miss;

  assign rd_ready = !out_valid_q || out_ready;
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin
    rd_data = valid_q[rd_index] ? mem_q[rd_index] : '0;
    rd_miss = !valid_q[rd_index];
`ifdef HIST_FWD_EN
    if (wr_en && (wp_q == rd_index)) begin
      rd_data = wr_data;
      rd_miss = 1'b0;
    end
`endif
  end

  // Pixel storage carries no reset; the valid vector decides what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      valid_q[wp_q] <= 1'b1;
      wp_q          <= wp_q + 6'd1;
      if (count_q != 7'd64) begin
        count_q <= count_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_miss_q  <= 1'b0;
    end else if (rd_fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rd_data;
      out_miss_q  <= rd_miss;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_miss  = out_miss_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pixel_history_reader.sv
// Directed plus randomized bench for pixel_history_reader against an array-based history model.
module tb_pixel_history_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [23:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic [5:0]  rd_index = '0;
  logic        rd_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_miss;
  logic [6:0]  count;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem_m [64];
  bit          valid_m [64];
  int          wp_m;
  int          count_m;
  bit          exp_ov;
  logic [23:0] exp_data;
  bit          exp_miss;

  pixel_history_reader #(.INP_BITS(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_index  (rd_index),
    .rd_ready  (rd_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_miss  (out_miss),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) valid_m[i] = 1'b0;
    wp_m = 0;
    count_m = 0;
    exp_ov = 1'b0;
    exp_data = '0;
    exp_miss = 1'b0;
  endtask

  // One clock: drive inputs just after an edge, model the edge, check #1 after it.
  task automatic step(input bit we, input logic [23:0] wd, input bit rv, input logic [5:0] ri,
                      input bit ordy);
    bit          acc;
    logic [23:0] d;
    bit          m;
    wr_en = we; wr_data = wd; rd_valid = rv; rd_index = ri; out_ready = ordy;
    #1;
    chk("rd_ready", 32'(rd_ready), 32'(!exp_ov || ordy));
    acc = rv && (!exp_ov || ordy);
    @(posedge clk);
    if (acc) begin
      m = !valid_m[ri];
      d = valid_m[ri] ? mem_m[ri] : 24'h0;
`ifdef HIST_FWD_EN
      if (we && wp_m == int'(ri)) begin
        d = wd;
        m = 1'b0;
      end
`endif
      exp_ov = 1'b1;
      exp_data = d;
      exp_miss = m;
    end else if (ordy) begin
      exp_ov = 1'b0;
    end
    if (we) begin
      mem_m[wp_m] = wd;
      valid_m[wp_m] = 1'b1;
      wp_m = (wp_m + 1) % 64;
      if (count_m < 64) count_m++;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("count", 32'(count), 32'(count_m));
    if (exp_ov) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_miss", 32'(out_miss), 32'(exp_miss));
    end
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_miss", 32'(out_miss), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_count", 32'(count), 32'd0);

    // Never-written slot reads back as a miss with zero data.
    step(0, 24'h0, 1, 6'd5, 1);
    chk("miss_slot5", 32'(out_miss), 32'd1);
    chk("miss_data5", 32'(out_data), 32'd0);

    step(1, 24'h112233, 0, 6'd0, 1);
    step(1, 24'h445566, 0, 6'd0, 1);
    step(1, 24'h778899, 0, 6'd0, 1);
    step(0, 24'h0, 1, 6'd0, 1);
    chk("b2b_0", 32'(out_data), 32'h112233);
    step(0, 24'h0, 1, 6'd1, 1);
    chk("b2b_1", 32'(out_data), 32'h445566);
    step(0, 24'h0, 1, 6'd2, 1);
    chk("b2b_2", 32'(out_data), 32'h778899);
    chk("count3", 32'(count), 32'd3);

    // Wrap: 65 writes leave slot 0 overwritten and count saturated.
    do_reset();
    for (int i = 0; i <= 64; i++) step(1, 24'(i), 0, 6'd0, 1);
    chk("count_sat", 32'(count), 32'd64);
    step(0, 24'h0, 1, 6'd0, 1);
    chk("wrap_slot0", 32'(out_data), 32'd64);
    step(0, 24'h0, 1, 6'd1, 1);
    chk("wrap_slot1", 32'(out_data), 32'd1);
    step(0, 24'h0, 1, 6'd63, 1);
    chk("wrap_slot63", 32'(out_data), 32'd63);

    // Backpressure: wp is 1 here, so these land in slots 1 and 2.
    step(1, 24'hAAAAAA, 0, 6'd0, 1);
    step(1, 24'hBBBBBB, 0, 6'd0, 1);
    step(0, 24'h0, 1, 6'd1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 24'h0, 1, 6'd2, 0);
      chk("hold_data", 32'(out_data), 32'hAAAAAA);
    end
    step(0, 24'h0, 1, 6'd2, 1);
    chk("refill_valid", 32'(out_valid), 32'd1);
    chk("refill_data", 32'(out_data), 32'hBBBBBB);
    step(0, 24'h0, 0, 6'd0, 1);
    chk("pop_empty", 32'(out_valid), 32'd0);

    // Collision at slot 3 once wp has come back round to 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 24'($urandom), 0, 6'd0, 1);
    step(1, 24'h010101, 0, 6'd0, 1);
    for (int i = 0; i < 63; i++) step(1, 24'($urandom), 0, 6'd0, 1);
    step(1, 24'h0F0F0F, 1, 6'd3, 1);
`ifdef HIST_FWD_EN
    chk("collide_fwd", 32'(out_data), 32'h0F0F0F);
`else
    chk("collide_rbw", 32'(out_data), 32'h010101);
`endif
    // First write to a slot colliding with a read of it.
    do_reset();
    step(1, 24'h123456, 1, 6'd0, 1);
    step(0, 24'h0, 1, 6'd0, 1);
    chk("after_first_write", 32'(out_data), 32'h123456);

    // Async reset with a result in flight.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 24'($urandom), 0, 6'd0, 1);
    step(0, 24'h0, 1, 6'd4, 0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd10);
    do_reset();
    chk("post_rst_ready", 32'(rd_ready), 32'd1);
    step(0, 24'h0, 1, 6'd0, 1);
    chk("post_rst_miss", 32'(out_miss), 32'd1);

    // Randomized traffic, biased towards reads of the slot being written.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] ri;
      ri = ($urandom_range(3) == 0) ? 6'(wp_m) : 6'($urandom);
      step(bit'($urandom_range(1)), 24'($urandom), bit'($urandom_range(3) != 0), ri,
           bit'($urandom_range(3) != 0));
      if (i == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_history_reader.md
# pixel_history_reader

Decoder-side counterpart of the encoder's 64-entry circular pixel CAM. Decoded pixels are written into the next circular slot. The index carried in the compressed stream is then resolved back to the stored pixel through a valid/ready read port with one registered output stage. Slot numbering and wrap order are identical to the encoder's CAM, so an index emitted by the encoder selects the same pixel here.

## Interface
- INP_BITS, 24, width of one stored pixel word
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  store wr_data in the slot at the write pointer this cycle
- wr_data  in  INP_BITS  pixel word to store
- rd_valid  in  1  read request present
- rd_index  in  6  absolute slot number to read (0..63)
- rd_ready  out  1  request accepted when rd_valid && rd_ready
- out_valid  out  1  out_data/out_miss hold a result
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_data  out  INP_BITS  pixel read from the requested slot
- out_miss  out  1  requested slot has not been written since reset
- count  out  7  number of slots written since reset, saturates at 64

## Operation
- Storage: 64 × INP_BITS array plus a 64-bit slot-valid vector and a 6-bit write pointer `wp`.
- Write: when wr_en = 1:
  - mem[wp] <= wr_data; valid[wp] <= 1; wp <= wp + 1 (63 wraps to 0).
  - Overwrite of the oldest entry after the wrap is normal.
- count increments on each write until it reaches 64, then holds at 64.
- Read acceptance: rd_ready = !out_valid || out_ready, i.e. a single output register with pass-through of backpressure.
- On an accepted read, next cycle:
  - out_valid = 1.
  - out_data = mem[rd_index], or 0 if the slot is invalid.
  - out_miss = !valid[rd_index].
- Output hold: out_data and out_miss are stable while out_valid && !out_ready.
- Pop without refill: if out_ready = 1 and no new request is accepted, out_valid falls next cycle.
- Back-to-back: accepting a new read in the same cycle as the pop keeps out_valid = 1 with the new data. Full throughput is one read per cycle.
- Array contents are not reset. Only the valid vector, wp, count and the output register are reset.

## Timing
- Read latency: 1 cycle, from the accept edge to out_valid.
- Write visibility: a write at edge N is readable by a request accepted at edge N+1 or later.
- Same-slot collision: a request accepted at the same edge as a write to rd_index is governed by HIST_FWD_EN (see Configuration).
- Reset values, async on rst = 1:
  - out_valid = 0, out_data = 0, out_miss = 0.
  - count = 0, wp = 0, all valid bits = 0.
  - rd_ready = 1 once rst deasserts.
- Reset mid-operation: an in-flight result is discarded, and the first read after release of a never-written slot returns out_miss = 1.
- Writes and reads are independent. Simultaneous wr_en and an accepted read to a different slot both complete in the same cycle.
- rd_index and wr_data are sampled only on accept or write cycles. They are don't-care otherwise.

## Configuration
- HIST_FWD_EN defined:
  - A read accepted in the same cycle as a write to the same slot returns the new wr_data with out_miss = 0 (write-to-read forwarding).
- HIST_FWD_EN undefined:
  - The same collision returns the pre-write contents, read-before-write.
  - out_miss reflects the pre-write valid bit, so the first write to a slot plus a same-cycle read gives out_miss = 1 and out_data = 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then read index 5 → next cycle out_valid = 1, out_miss = 1, out_data = 0; count = 0.
- Write 0x112233, 0x445566, 0x778899 on three cycles, then read 0, 1, 2 back-to-back with out_ready = 1:
  - out_data = 0x112233, 0x445566, 0x778899 on consecutive cycles, out_miss = 0.
  - count = 3.
- Write 65 words with values 0..64:
  - count = 64; wp = 1.
  - Read 0 → 64 (overwritten). Read 1 → 1. Read 63 → 63.
- Backpressure: accept a read of slot 1 (value 0xAAAAAA) and hold out_ready = 0 for 4 cycles:
  - rd_ready = 0 and out_data stable at 0xAAAAAA throughout.
  - On out_ready = 1 with a new request for slot 2 (0xBBBBBB), out_valid stays 1 and out_data becomes 0xBBBBBB next cycle.
- Collision: slot 3 holds 0x010101; in one cycle write 0x0F0F0F with wp = 3 and accept a read of 3:
  - With HIST_FWD_EN: out_data = 0x0F0F0F.
  - Without: out_data = 0x010101.
- Assert rst while out_valid = 1 and count = 10:
  - out_valid = 0, count = 0 immediately, without waiting for a clock edge.
  - After release, a read of slot 0 returns out_miss = 1.
